// File: rtl/gpu_pkg.sv
// Shared constants, vertex type and setup FSM state encoding for the triangle front end.
package gpu_pkg;

  localparam int unsigned SCREEN_W      = 320;
  localparam int unsigned SCREEN_H      = 240;
  localparam int unsigned INV_FRAC_BITS = 24;

  localparam int unsigned XWidth    = 9;
  localparam int unsigned YWidth    = 8;
  localparam int unsigned ZWidth    = 16;
  localparam int unsigned AWidth    = 9;
  localparam int unsigned BWidth    = 10;
  localparam int unsigned CWidth    = 19;
  localparam int unsigned ProdWidth = 18;
  localparam int unsigned AreaWidth = 19;
  localparam int unsigned DivWidth  = 18;
  localparam int unsigned QuotWidth = 32;

  localparam logic [XWidth-1:0] XMax = XWidth'(SCREEN_W - 1);
  localparam logic [YWidth-1:0] YMax = YWidth'(SCREEN_H - 1);

  typedef struct packed {
    logic [XWidth-1:0] x;
    logic [YWidth-1:0] y;
    logic [ZWidth-1:0] z;
  } vertex_t;

  typedef enum logic [2:0] {
    StIdle,
    StEdge,
    StArea,
    StOrient,
    StDiv,
    StStart,
    StWait
  } tri_state_e;

  // |area2| always fits the divisor because the largest on-grid area2 is below 2^18.
  function automatic logic [DivWidth-1:0] abs_area(input logic signed [AreaWidth-1:0] a);
    logic signed [AreaWidth-1:0] m;
    m = a[AreaWidth-1] ? -a : a;
    return m[DivWidth-1:0];
  endfunction

endpackage

// File: rtl/recip_div.sv
// Sequential restoring divider computing floor(2^INV_FRAC_BITS / divisor), one quotient bit
// per cycle over a fixed 32-cycle run; done is high during the final iteration.
module recip_div
  import gpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DivWidth-1:0]  divisor,
  output logic [QuotWidth-1:0] quotient,
  output logic                 done
);

  // Iteration index at which the single set dividend bit is shifted in.
  localparam logic [4:0] OneBitCnt = 5'(QuotWidth - 1 - INV_FRAC_BITS);

  logic                 busy_q;
  logic [4:0]           cnt_q;
  logic [DivWidth-1:0]  rem_q;
  logic [DivWidth-1:0]  div_q;
  logic [QuotWidth-1:0] quot_q;

  logic                 dbit;
  logic [DivWidth:0]    rem_sh;
  logic [DivWidth-1:0]  rem_diff;
  logic                 fits;

  always_comb begin
    dbit     = (cnt_q == OneBitCnt);
    rem_sh   = {rem_q, dbit};
    fits     = (rem_sh >= {1'b0, div_q});
    rem_diff = rem_sh[DivWidth-1:0] - div_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      div_q  <= divisor;
      quot_q <= '0;
    end else if (busy_q) begin
      rem_q  <= fits ? rem_diff : rem_sh[DivWidth-1:0];
      quot_q <= {quot_q[QuotWidth-2:0], fits};
      cnt_q  <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) busy_q <= 1'b0;
    end
  end

  assign quotient = quot_q;
  assign done     = busy_q && (cnt_q == 5'd31);

endmodule

// File: rtl/tri_setup.sv
// Triangle setup: edge equations, clamped bbox, winding fix-up and 1/area2 ahead of the
// rasterizer. Define TRI_BACKFACE_CULL_EN to cull clockwise triangles instead of swapping them.
module tri_setup
  import gpu_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tri_valid,
  output logic                        tri_ready,
  input  logic        [XWidth-1:0]    x1,
  input  logic        [XWidth-1:0]    x2,
  input  logic        [XWidth-1:0]    x3,
  input  logic        [YWidth-1:0]    y1,
  input  logic        [YWidth-1:0]    y2,
  input  logic        [YWidth-1:0]    y3,
  input  logic        [ZWidth-1:0]    z1i,
  input  logic        [ZWidth-1:0]    z2i,
  input  logic        [ZWidth-1:0]    z3i,
  input  logic        [7:0]           color_in,
  output logic signed [AWidth-1:0]    a1,
  output logic signed [AWidth-1:0]    a2,
  output logic signed [AWidth-1:0]    a3,
  output logic signed [BWidth-1:0]    b1,
  output logic signed [BWidth-1:0]    b2,
  output logic signed [BWidth-1:0]    b3,
  output logic signed [CWidth-1:0]    c1,
  output logic signed [CWidth-1:0]    c2,
  output logic signed [CWidth-1:0]    c3,
  output logic        [XWidth-1:0]    bbxi,
  output logic        [XWidth-1:0]    bbxf,
  output logic        [YWidth-1:0]    bbyi,
  output logic        [YWidth-1:0]    bbyf,
  output logic        [ZWidth-1:0]    z1,
  output logic        [ZWidth-1:0]    z2,
  output logic        [ZWidth-1:0]    z3,
  output logic        [7:0]           color,
  output logic        [QuotWidth-1:0] inv_area,
  output logic                        rasterizer_start,
  input  logic                        rasterizer_done,
  output logic                        busy
);

  tri_state_e state_q;
  logic       tri_ready_q;
  logic       start_q;
  logic       busy_q;

  vertex_t                     v_q [3];
  logic        [7:0]           color_q;
  logic signed [AWidth-1:0]    a_q [3];
  logic signed [BWidth-1:0]    b_q [3];
  logic signed [CWidth-1:0]    c_q [3];
  logic        [ProdWidth-1:0] p_q [6];
  logic signed [AreaWidth-1:0] area2_q;
  logic        [XWidth-1:0]    bbxi_q, bbxf_q;
  logic        [YWidth-1:0]    bbyi_q, bbyf_q;

  logic signed [19:0]          dx21, dy31, dx31, dy21, area_full;
  logic        [XWidth-1:0]    xmin, xmax;
  logic        [YWidth-1:0]    ymin, ymax;
  logic                        degenerate;
  logic                        cull;
  logic                        swap;
  logic                        div_start;
  logic                        div_done;
  logic        [DivWidth-1:0]  divisor;
  logic        [QuotWidth-1:0] quotient;

  // Vertex coordinates are non-negative, so zero extension equals sign extension here.
  always_comb begin
    dx21      = 20'(v_q[1].x) - 20'(v_q[0].x);
    dx31      = 20'(v_q[2].x) - 20'(v_q[0].x);
    dy21      = 20'(v_q[1].y) - 20'(v_q[0].y);
    dy31      = 20'(v_q[2].y) - 20'(v_q[0].y);
    area_full = dx21 * dy31 - dx31 * dy21;

    xmin = v_q[0].x;
    xmax = v_q[0].x;
    ymin = v_q[0].y;
    ymax = v_q[0].y;
    for (int i = 1; i < 3; i++) begin
      if (v_q[i].x < xmin) xmin = v_q[i].x;
      if (v_q[i].x > xmax) xmax = v_q[i].x;
      if (v_q[i].y < ymin) ymin = v_q[i].y;
      if (v_q[i].y > ymax) ymax = v_q[i].y;
    end
  end

  // Only the upper bound is clamped, so an all-off-screen triangle shows up as min > max.
  always_comb begin
    degenerate = (area2_q == '0) || (bbxi_q > bbxf_q) || (bbyi_q > bbyf_q);
    swap       = area2_q[AreaWidth-1];
`ifdef TRI_BACKFACE_CULL_EN
    cull       = degenerate || swap;
`else
    cull       = degenerate;
`endif
    div_start  = (state_q == StOrient) && !cull;
    divisor    = abs_area(area2_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        v_q[i] <= '0;
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
      for (int i = 0; i < 6; i++) p_q[i] <= '0;
      color_q <= '0;
      area2_q <= '0;
      bbxi_q  <= '0;
      bbxf_q  <= '0;
      bbyi_q  <= '0;
      bbyf_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (tri_valid) begin
            v_q[0]  <= '{x: x1, y: y1, z: z1i};
            v_q[1]  <= '{x: x2, y: y2, z: z2i};
            v_q[2]  <= '{x: x3, y: y3, z: z3i};
            color_q <= color_in;
          end
        end
        StEdge: begin
          for (int i = 0; i < 3; i++) begin
            a_q[i]     <= AWidth'(v_q[(i+1)%3].y) - AWidth'(v_q[(i+2)%3].y);
            b_q[i]     <= BWidth'(v_q[(i+2)%3].x) - BWidth'(v_q[(i+1)%3].x);
            p_q[2*i]   <= ProdWidth'(v_q[(i+1)%3].x) * ProdWidth'(v_q[(i+2)%3].y);
            p_q[2*i+1] <= ProdWidth'(v_q[(i+2)%3].x) * ProdWidth'(v_q[(i+1)%3].y);
          end
        end
        StArea: begin
          for (int i = 0; i < 3; i++) begin
            c_q[i] <= CWidth'(p_q[2*i]) - CWidth'(p_q[2*i+1]);
          end
          area2_q <= area_full[AreaWidth-1:0];
          bbxi_q  <= xmin;
          bbxf_q  <= (xmax > XMax) ? XMax : xmax;
          bbyi_q  <= ymin;
          bbyf_q  <= (ymax > YMax) ? YMax : ymax;
        end
        StOrient: begin
          // Relabel v2<->v3 so every edge function is non-negative inside.
          if (!cull && swap) begin
            a_q[0]   <= -a_q[0];
            a_q[1]   <= -a_q[2];
            a_q[2]   <= -a_q[1];
            b_q[0]   <= -b_q[0];
            b_q[1]   <= -b_q[2];
            b_q[2]   <= -b_q[1];
            c_q[0]   <= -c_q[0];
            c_q[1]   <= -c_q[2];
            c_q[2]   <= -c_q[1];
            area2_q  <= -area2_q;
            v_q[1].z <= v_q[2].z;
            v_q[2].z <= v_q[1].z;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tri_ready_q <= 1'b1;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (tri_valid) begin
            state_q     <= StEdge;
            tri_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        StEdge:   state_q <= StArea;
        StArea:   state_q <= StOrient;
        StOrient: begin
          if (cull) begin
            state_q     <= StIdle;
            tri_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            state_q <= StDiv;
          end
        end
        StDiv: begin
          if (div_done) begin
            state_q <= StStart;
            start_q <= 1'b1;
          end
        end
        StStart:  state_q <= StWait;
        StWait: begin
          if (rasterizer_done) begin
            state_q     <= StIdle;
            tri_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          tri_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  recip_div u_recip_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .divisor  (divisor),
    .quotient (quotient),
    .done     (div_done)
  );

  assign tri_ready        = tri_ready_q;
  assign rasterizer_start = start_q;
  assign busy             = busy_q;
  assign a1               = a_q[0];
  assign a2               = a_q[1];
  assign a3               = a_q[2];
  assign b1               = b_q[0];
  assign b2               = b_q[1];
  assign b3               = b_q[2];
  assign c1               = c_q[0];
  assign c2               = c_q[1];
  assign c3               = c_q[2];
  assign bbxi             = bbxi_q;
  assign bbxf             = bbxf_q;
  assign bbyi             = bbyi_q;
  assign bbyf             = bbyf_q;
  assign z1               = v_q[0].z;
  assign z2               = v_q[1].z;
  assign z3               = v_q[2].z;
  assign color            = color_q;
  assign inv_area         = quotient;

endmodule

// File: doc/tri_setup.md
Name: tri_setup

Overview:
- Triangle setup stage directly upstream of the rasterizer.
- Accepts one screen-space triangle from the MicroBlaze register interface: three vertices with x, y, z, plus a color.
- Computes the three edge-equation coefficients, the clamped bounding box and the fixed-point inverse of twice the signed area. Normalises winding so every edge function is >= 0 inside the triangle.
- Launches the rasterizer, holds all outputs stable until the rasterizer reports done, and culls degenerate or off-screen triangles without launching.

Parameters:
- SCREEN_W, 320, framebuffer width in pixels.
- SCREEN_H, 240, framebuffer height in pixels.
- INV_FRAC_BITS, 24, fraction bits of inv_area; inv_area = floor(2^INV_FRAC_BITS / area2).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- tri_valid  in  1  upstream has a triangle on the vertex inputs.
- tri_ready  out  1  block is accepting; a triangle transfers on a clock edge where tri_valid && tri_ready.
- x1, x2, x3  in  9 each  unsigned vertex x.
- y1, y2, y3  in  8 each  unsigned vertex y.
- z1i, z2i, z3i  in  16 each  vertex depth.
- color_in  in  8  triangle color.
- a1, a2, a3  out  9 signed each  edge x-coefficients.
- b1, b2, b3  out  10 signed each  edge y-coefficients.
- c1, c2, c3  out  19 signed each  edge constants.
- bbxi, bbxf  out  9 each  bounding box x range, inclusive.
- bbyi, bbyf  out  8 each  bounding box y range, inclusive.
- z1, z2, z3  out  16 each  depths reordered to match the winding.
- color  out  8  latched color.
- inv_area  out  32  unsigned Q.INV_FRAC_BITS reciprocal of area2.
- rasterizer_start  out  1  one-cycle launch pulse.
- rasterizer_done  in  1  one-cycle completion pulse from the rasterizer.
- busy  out  1  high in every state except S_IDLE.

Behaviour:
- Reset: state = S_IDLE; tri_ready=1, rasterizer_start=0, busy=0; all data outputs = 0. Reset in any state, including mid-divide or mid-S_WAIT, aborts the triangle. No start pulse follows.
- Edge definitions:
  - E1 is opposite v1: a1 = y2-y3, b1 = x3-x2, c1 = x2*y3 - x3*y2.
  - E2 and E3 are cyclic: (2,3,1) and (3,1,2).
  - area2 = E1 evaluated at v1 = (x2-x1)(y3-y1) - (x3-x1)(y2-y1), 19-bit signed.
- States and timing (T = accept edge):
  - S_IDLE: tri_ready=1. On accept, latch all inputs -> S_EDGE.
  - S_EDGE (T+1): register a, b and the six c products.
  - S_AREA (T+2): register c and area2. Register bbox: min/max of the vertices, clamped to [0, SCREEN_W-1] and [0, SCREEN_H-1].
  - S_ORIENT (T+3), in priority order:
    1. area2 == 0, or clamped bbox empty (min > max, i.e. all vertices off-screen) -> cull.
    2. area2 < 0 -> swap v2/v3 in registers: a1 = -a1, a2 = -a3, a3 = -a2 (same for b and c); area2 = -area2; swap z2/z3. Then go to S_DIV.
    3. Otherwise -> S_DIV.
  - Cull: return to S_IDLE, so tri_ready=1 in cycle T+4.
  - S_DIV (T+4..T+35): restoring divide of 2^INV_FRAC_BITS by area2, 32 iterations, one quotient bit per cycle.
  - S_START (T+36): rasterizer_start=1 for exactly this cycle.
  - S_WAIT: hold every output stable. On rasterizer_done -> S_IDLE, so tri_ready=1 the next cycle.
- tri_valid during busy is ignored (not latched).
- rasterizer_done outside S_WAIT is ignored.
- Arithmetic:
  - All differences are sign-extended before use.
  - Products are 18-bit unsigned operands extended to 19-bit signed.
  - No saturation is needed at 320x240 bounds.

Optional Feature:
- TRI_BACKFACE_CULL_EN defined: area2 < 0 is culled like a degenerate triangle (S_ORIENT -> S_IDLE, no swap, no start pulse).
- Undefined: clockwise triangles are swapped and drawn (default).

Decomposition:
- Package gpu_pkg holds:
  - SCREEN_W, SCREEN_H, INV_FRAC_BITS;
  - typedef vertex_t {x[8:0], y[7:0], z[15:0]};
  - typedef of the tri_setup state enum;
  - edge coefficient widths as localparams.
- Sub-module recip_div: sequential restoring divider.
  - Ports: start, divisor[17:0], quotient[31:0], done.
  - Fixed 32-cycle latency.
  - Synchronous reset on rst.

Test Plan:
- CCW (10,10),(50,10),(10,50) -> start at T+36.
  - Edges: a = (-40, 40, 0), b = (-40, 0, 40), c = (2400, -400, -400).
  - bbox 10..50 x 10..50; inv_area = 10485.
- CW (10,10),(10,50),(50,10), z = (1,2,3) -> outputs identical to the CCW case, with z out = (1,3,2). With TRI_BACKFACE_CULL_EN: no start pulse, tri_ready=1 at T+4.
- Collinear (0,0),(10,10),(20,20) -> no start pulse; tri_ready=1 at T+4.
- Vertices (300,10),(400,10),(300,200) -> bbxf=319, bbyf=200. All x >= 320 -> culled.
- Backpressure: tri_valid held high after start -> no second accept until one cycle after rasterizer_done. Outputs stable throughout S_WAIT.
- Reset at T+20 (mid-divide) -> tri_ready=1 and all outputs 0 the next cycle; no start pulse. A new triangle then completes normally.
